// File: rtl/uart_prog_loader_pkg.sv
// Shared types and constants for the UART program loader and its receiver.
// Holds the loader/receiver state encodings, frame header byte and default baud divisor.
package uart_prog_loader_pkg;

    localparam logic [7:0]  HDR_BYTE             = 8'hA5;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_DONE,
        ST_ERROR
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling baud counter, LSB-first shifter.
// byte_valid / frame_err pulse for one cycle in the cycle the stop bit is sampled.
module uart_rx_core
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned      CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_t        state_q, state_d;
    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             cnt_half, cnt_full, fall;

    assign cnt_half = (cnt_q == HALF_CNT);
    assign cnt_full = (cnt_q == FULL_CNT);
    // Edge-triggered start detection so a low tail after a bad stop bit cannot re-arm.
    assign fall     = !sync2_q && prev_q;
    assign rx_byte  = shift_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= RX_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (fall) state_d = RX_START;
            RX_START: if (cnt_half) state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (cnt_full && bit_idx_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (cnt_full) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        if (state_q == RX_STOP && cnt_full) begin
            byte_valid = sync2_q;
            frame_err  = !sync2_q;
        end
    end

    always_comb begin
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            RX_START: if (cnt_half) cnt_d = '0;
            RX_DATA: begin
                if (cnt_full) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            RX_STOP: if (cnt_full) cnt_d = '0;
            default: cnt_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: parses A5/count/payload frames and streams 32-bit words into imem.
// Holds the CPU in reset while a load session is active.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              start_load,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [32:0] MAX_WORDS = 33'(1) << ADDR_W;

    logic [7:0]  rx_byte;
    logic        byte_valid, frame_err;

    load_state_t       state_q, state_d;
    logic [15:0]       count_q, count_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       asm_q, asm_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [15:0] len_full;
    logic        session_active, can_start, last_written;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign len_full       = {rx_byte, count_q[7:0]};
    assign session_active = (state_q == ST_HDR) || (state_q == ST_LEN_LO) ||
                            (state_q == ST_LEN_HI) || (state_q == ST_DATA);
    assign can_start      = start_load && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                           (state_q == ST_ERROR));
    // idx_q has already advanced past the word being strobed.
    assign last_written   = we_q && (33'(idx_q) == 33'(count_q));

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start_load) state_d = ST_HDR;
            ST_HDR:    if (byte_valid && rx_byte == HDR_BYTE) state_d = ST_LEN_LO;
            ST_LEN_LO: if (byte_valid) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (byte_valid) begin
                    if (len_full == 16'd0)                    state_d = ST_DONE;
                    else if ({17'd0, len_full} > MAX_WORDS)   state_d = ST_ERROR;
                    else                                      state_d = ST_DATA;
                end
            end
            ST_DATA:   if (last_written) state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
        if (session_active && frame_err) state_d = ST_ERROR;
    end

    always_comb begin
        cpu_hold = session_active;
        done     = (state_q == ST_DONE);
        err      = (state_q == ST_ERROR);
    end

    always_comb begin
        count_d    = count_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        if (can_start) begin
            idx_d      = '0;
            byte_cnt_d = '0;
        end
        case (state_q)
            ST_LEN_LO: if (byte_valid) count_d = {count_q[15:8], rx_byte};
            ST_LEN_HI: if (byte_valid) count_d = len_full;
            ST_DATA: begin
                if (byte_valid) begin
                    asm_d      = {rx_byte, asm_q[31:8]};
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        waddr_d = idx_q[ADDR_W-1:0];
                        wdata_d = {rx_byte, asm_q[31:8]};
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            idx_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            count_q    <= count_d;
            idx_q      <= idx_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_waddr = waddr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: serial frames in, logged imem writes and status checked.
module tb_uart_prog_loader;

    localparam int unsigned CPB    = 104;
    localparam int unsigned ADDR_W = 12;

    typedef logic [7:0] byte_q_t[$];

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              start_load;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_total = 0;
    int bv_total = 0;
    logic [ADDR_W-1:0] wr_addr [16];
    logic [31:0]       wr_data [16];

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .start_load(start_load),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_total < 16) begin
                wr_addr[wr_total] = imem_waddr;
                wr_data[wr_total] = imem_wdata;
            end
            wr_total++;
        end
        if (dut.u_rx.byte_valid === 1'b1) bv_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB / 4) @(negedge clk);
    endtask

    task automatic send_seq(input byte_q_t s);
        foreach (s[i]) send_byte(s[i], 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_load = 1'b1;
        @(negedge clk);
        start_load = 1'b0;
    endtask

    initial begin
        byte_q_t seq;
        int base;
        int bv0;

        rst = 1'b1;
        rx = 1'b1;
        start_load = 1'b0;
        idle(5);
        check("rst_we", imem_we, 1'b0);
        check("rst_waddr", imem_waddr, '0);
        check("rst_wdata", imem_wdata, 32'h0);
        check("rst_hold", cpu_hold, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        rst = 1'b0;
        idle(10);

        // Two-word program
        base = wr_total;
        pulse_start();
        check("t1_hold_on", cpu_hold, 1'b1);
        check("t1_done_clr", done, 1'b0);
        seq = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'hB3, 8'h02, 8'hB5, 8'h00};
        send_seq(seq);
        idle(10);
        check("t1_nwr", wr_total - base, 2);
        check("t1_addr0", wr_addr[base], 0);
        check("t1_data0", wr_data[base], 32'h0010_0513);
        check("t1_addr1", wr_addr[base + 1], 1);
        check("t1_data1", wr_data[base + 1], 32'h00B5_02B3);
        check("t1_done", done, 1'b1);
        check("t1_hold_off", cpu_hold, 1'b0);
        check("t1_err", err, 1'b0);

        // Junk before header, zero-length program
        base = wr_total;
        pulse_start();
        seq = '{8'h3C, 8'hA5, 8'h00, 8'h00};
        send_seq(seq);
        idle(10);
        check("t2_nwr", wr_total - base, 0);
        check("t2_done", done, 1'b1);
        check("t2_err", err, 1'b0);

        // Count one past the address space
        base = wr_total;
        pulse_start();
        check("t3_done_clr", done, 1'b0);
        seq = '{8'hA5, 8'h01, 8'h10};
        send_seq(seq);
        idle(10);
        check("t3_err", err, 1'b1);
        check("t3_done", done, 1'b0);
        check("t3_hold", cpu_hold, 1'b0);
        check("t3_nwr", wr_total - base, 0);

        // Framing error on the third payload byte
        base = wr_total;
        pulse_start();
        check("t4_err_clr", err, 1'b0);
        seq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_seq(seq);
        send_byte(8'h33, 1'b0);
        idle(10);
        check("t4_err", err, 1'b1);
        check("t4_hold", cpu_hold, 1'b0);
        check("t4_nwr", wr_total - base, 0);
        send_byte(8'h44, 1'b1);
        idle(10);
        check("t4_nwr_late", wr_total - base, 0);
        check("t4_err_stay", err, 1'b1);

        // Reset mid-word, then a clean frame
        base = wr_total;
        pulse_start();
        seq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE};
        send_seq(seq);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        check("t5_rst_hold", cpu_hold, 1'b0);
        check("t5_rst_err", err, 1'b0);
        check("t5_rst_done", done, 1'b0);
        seq = '{8'hAD, 8'hDE};
        send_seq(seq);
        idle(10);
        check("t5_nwr_orphan", wr_total - base, 0);
        pulse_start();
        seq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_seq(seq);
        idle(10);
        check("t5_nwr", wr_total - base, 1);
        check("t5_addr0", wr_addr[base], 0);
        check("t5_data0", wr_data[base], 32'hDEAD_BEEF);
        check("t5_done", done, 1'b1);

        // Short low glitch while waiting for header
        pulse_start();
        bv0 = bv_total;
        rx = 1'b0;
        idle(20);
        rx = 1'b1;
        idle(2 * CPB);
        check("t6_no_byte", bv_total - bv0, 0);
        check("t6_hold", cpu_hold, 1'b1);
        check("t6_done", done, 1'b0);
        seq = '{8'hA5, 8'h00, 8'h00};
        send_seq(seq);
        idle(10);
        check("t6_bytes", bv_total - bv0, 3);
        check("t6_done_after", done, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clk cycles per UART bit.
REQ-002 SHALL have parameter ADDR_W, default 12, instruction-memory word-address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rx  input  1  UART serial in, 8N1, idle high, asynchronous to clk.
REQ-006 SHALL have port start_load  input  1  level; arms a load session when sampled high in IDLE, DONE or ERROR.
REQ-007 SHALL have port imem_we  output  1  one-cycle instruction-memory write strobe.
REQ-008 SHALL have port imem_waddr  output  ADDR_W  word address for the write.
REQ-009 SHALL have port imem_wdata  output  32  instruction word for the write.
REQ-010 SHALL have port cpu_hold  output  1  high while a session is active; holds the CPU in reset.
REQ-011 SHALL have port done  output  1  sticky; last session completed.
REQ-012 SHALL have port err  output  1  sticky; last session aborted.

Function
REQ-013 Frame format SHALL be: header 0xA5, count_lo, count_hi, then 4*count payload bytes, with each word little-endian.
REQ-014 FSM states SHALL be IDLE, HDR, LEN_LO, LEN_HI, DATA, DONE, ERROR.
REQ-015 IDLE/DONE/ERROR with start_load=1 SHALL go to HDR next cycle, set cpu_hold=1, clear done/err, and reset word address to 0.
REQ-016 HDR SHALL discard any byte other than 0xA5 and stay in HDR; 0xA5 SHALL advance to LEN_LO.
REQ-017 LEN_LO/LEN_HI SHALL latch the 16-bit count; after LEN_HI, count=0 SHALL go to DONE, count>2^ADDR_W SHALL go to ERROR, and any other count SHALL go to DATA.
REQ-018 DATA SHALL shift bytes into a 32-bit assembler, first byte into bits [7:0].
REQ-019 On the 4th byte of each word, imem_we SHALL be 1 for exactly the next cycle, with imem_wdata=assembled word and imem_waddr=current index; the index SHALL then increment.
REQ-020 After the write of word count-1, the FSM SHALL enter DONE in the cycle after the strobe, set done=1 and cpu_hold=0.
REQ-021 A framing error (stop bit sampled 0) in any active state SHALL go to ERROR, set err=1, cpu_hold=0, and suppress any pending partial word.
REQ-022 start_load while in HDR/LEN_LO/LEN_HI/DATA SHALL be ignored.
REQ-023 The RX path SHALL use a 2-FF synchronizer; a start bit SHALL be confirmed at half a bit time, and data SHALL be sampled at mid-bit using CLKS_PER_BIT counts.
REQ-024 A start bit that is low for less than CLKS_PER_BIT/2 SHALL be rejected; the receiver SHALL return to idle with no byte.
REQ-025 The byte-valid pulse SHALL be one cycle wide, asserted in the cycle the stop bit is sampled.
REQ-026 imem_waddr SHALL not wrap; REQ-017 guarantees the index stays ≤ 2^ADDR_W-1.

Reset
REQ-027 rst=1 SHALL force, at the next edge: FSM=IDLE, imem_we=0, imem_waddr=0, imem_wdata=0, cpu_hold=0, done=0, err=0, RX core idle, baud counter=0.
REQ-028 rst mid-session SHALL abandon the session; no further imem_we until a new start_load.

Structure
REQ-029 A shared package SHALL hold the FSM state enum, HDR_BYTE=0xA5 and the default CLKS_PER_BIT.
REQ-030 One sub-module uart_rx_core SHALL hold the synchronizer, baud counter and bit shifter, and SHALL output byte[7:0], byte_valid and frame_err.
REQ-031 The top SHALL hold only the FSM, count/index registers and the word assembler; target 150-300 RTL lines total.

Verification
REQ-032 start_load, then bytes A5 02 00 13 05 10 00 B3 02 B5 00 -> writes addr0=0x00100513 and addr1=0x00B502B3, done=1, cpu_hold=0.
REQ-033 Bytes 3C A5 00 00 -> 0x3C ignored, no imem_we, DONE reached, done=1.
REQ-034 A5 with count 0x1001 and ADDR_W=12 -> ERROR, err=1, zero writes.
REQ-035 Stop bit forced 0 on the 3rd payload byte -> ERROR, err=1, no imem_we for that word.
REQ-036 rst pulsed after 2 of 4 payload bytes, then full frame A5 01 00 EF BE AD DE -> single write addr0=0xDEADBEEF.
REQ-037 A 20-cycle low glitch on rx (CLKS_PER_BIT=104) -> no byte_valid, FSM state unchanged.
